ps2_key_tracker: RTL and testbench
==================================

# ps2_key_tracker

Upstream input stage for the player movement modules. It receives raw PS/2 keyboard frames on the 50 MHz system clock and decodes scan-code set 2 make/break sequences. It drives level-held key flags: w_key, a_key and d_key go to Fireboy, and up_key, left_key and right_key go to Watergirl. The flags are stable between frames and are sampled by the movers on their frame_clk rising edge.

## Interface
- TIMEOUT_CYCLES, 50000: idle Clk cycles (about 1 ms) after which a partial frame is abandoned.
- Clk  in  1  50 MHz system clock.
- Reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- ps2_clk  in  1  raw PS/2 clock, asynchronous to Clk.
- ps2_data  in  1  raw PS/2 data, asynchronous to Clk.
- w_key, a_key, d_key  out  1 each  held flags for scan codes 1D, 1C, 23.
- up_key, left_key, right_key  out  1 each  held flags for extended codes E0 75, E0 6B, E0 74.
- frame_err  out  1  one-cycle pulse when a frame is discarded (start, parity or stop error, or timeout).

## Operation
- ps2_clk and ps2_data each pass through a 2-flop synchronizer.
- A third flop on ps2_clk detects falling edges.
- Sampling is done on each detected falling edge, collecting 11 bits:
  - start bit, must be 0;
  - 8 data bits, LSB first;
  - odd parity bit;
  - stop bit, must be 1.
- Bit counter is 4 bits, counting 0..10.
- Start bit sampled as 1: counter stays 0, no error pulse (resync).
- At bit 10 the frame is checked:
  - parity OK and stop bit 1: byte_valid pulses for one cycle with the byte.
  - otherwise: frame_err pulses and no byte is produced.
  - either way, the counter returns to 0.
- Timeout counter:
  - clears on every falling edge and whenever the bit counter is 0;
  - when it reaches TIMEOUT_CYCLES-1 with the counter nonzero, the counter is cleared and frame_err pulses.
- Decoder FSM states are IDLE, EXT, BRK and EXT_BRK. It advances only on byte_valid:
  - IDLE: E0 goes to EXT; F0 goes to BRK; any other byte sets the matching base flag and stays in IDLE.
  - EXT: F0 goes to EXT_BRK; any other byte sets the matching extended flag and goes to IDLE.
  - BRK: any byte clears the matching base flag and goes to IDLE.
  - EXT_BRK: any byte clears the matching extended flag and goes to IDLE.
- Unlisted codes change no flag but still advance the FSM.
- Base and extended tables are distinct. For example, 75 without E0 does not touch up_key.
- Typematic repeats (repeated make codes) leave the flag at 1.
- Any frame_err forces the FSM to IDLE. Flags are untouched.
- Simultaneous keys: each flag is independent. Conflict resolution (a plus d) belongs to the consumer.

## Timing
- Reset values: all key flags 0, frame_err 0, FSM IDLE, bit and timeout counters 0, synchronizers 1 (bus idle high).
- Reset is asynchronous. Asserting it mid-frame discards the partial frame. After deassertion the receiver waits for a fresh start bit.
- Falling edge detect occurs 3 Clk cycles after the ps2_clk pin edge.
- byte_valid and frame_err are asserted in the cycle after the 11th sampled edge.
- Key flag updates on the Clk edge following byte_valid. Total pin-to-flag latency is 5 Clk cycles after the stop-bit falling edge.
- frame_err is exactly one cycle wide and never coincides with byte_valid.
- Timeout and falling edge in the same cycle: the edge wins, the bit is sampled and the timeout clears.

## Structure
- Shared package ps2_pkg holds:
  - the decoder state typedef (IDLE, EXT, BRK, EXT_BRK);
  - scan-code localparams: SC_E0 = 8'hE0, SC_F0 = 8'hF0, SC_W = 8'h1D, SC_A = 8'h1C, SC_D = 8'h23, SC_UP = 8'h75, SC_LEFT = 8'h6B, SC_RIGHT = 8'h74.
- Sub-module ps2_rx contains the synchronizers, edge detect, shift register, parity/stop check and timeout. It outputs byte_valid, byte_data and frame_err.
- Top ps2_key_tracker instantiates ps2_rx and contains the decoder FSM and the flag registers.

## Test plan
- Send frame 1D (correct odd parity) -> w_key rises 5 cycles after the stop edge. Then send F0, 1D -> w_key returns to 0. No other flag moves.
- Send E0 6B -> left_key = 1 while a_key stays 0. Then send E0 F0 6B -> left_key = 0.
- Send 1C then 23 with no break codes -> a_key = 1 and d_key = 1 together. Repeat 1C five times -> a_key stays 1.
- Send 23 with the parity bit flipped -> frame_err pulses once and d_key stays 0. A following valid 23 sets d_key.
- Send E0, then 4 bits of a frame, then idle 50000 cycles -> frame_err pulses and the FSM returns to IDLE. A subsequent 75 leaves up_key at 0, because the E0 prefix was cleared by the error.
- Pull Reset_n low mid-frame with w_key = 1 -> all flags drop to 0 immediately. After release, a full 1D frame sets w_key normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 key tracker.
package ps2_pkg;

    // Decoder position within a make/break/extended byte sequence.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } dec_state_t;

    // Held key flags, one bit per tracked key.
    typedef struct packed {
        logic w;
        logic a;
        logic d;
        logic up;
        logic left;
        logic right;
    } key_flags_t;

    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // Return the flag set with the key matching (ext, code) forced to val.
    // Codes outside the selected table leave every flag unchanged.
    function automatic key_flags_t apply_code(input key_flags_t flags,
                                              input logic       ext,
                                              input logic [7:0] code,
                                              input logic       val);
        key_flags_t r;
        // NOTE: blocking assignments are right inside functions and always_comb;
        // only clocked always_ff state uses non-blocking <=.
        r = flags;
        if (!ext) begin
            case (code)
                SC_W:    r.w = val;
                SC_A:    r.a = val;
                SC_D:    r.d = val;
                default: ;
            endcase
        end else begin
            case (code)
                SC_UP:    r.up    = val;
                SC_LEFT:  r.left  = val;
                SC_RIGHT: r.right = val;
                default:  ;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizes the bus, samples 11-bit frames on
// falling ps2_clk edges, checks start/parity/stop and abandons stalled frames.
module ps2_rx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int             TW      = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic          clk_s1, clk_s2, clk_s3;
    logic          data_s1, data_s2;
    logic          fall_q;
    logic [3:0]    bit_cnt;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic [TW-1:0] to_cnt;
    logic          timeout;

    // A stalled partial frame times out; a falling edge in the same cycle wins.
    assign timeout = !fall_q && (bit_cnt != 4'd0) && (to_cnt == TO_LAST);

    // Two-flop synchronizers (idle-high reset) plus registered falling-edge pulse.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            clk_s3  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            clk_s3  <= clk_s2;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
            fall_q  <= clk_s3 & ~clk_s2;
        end
    end

    // Bit collection and frame check; byte_valid/frame_err are one-cycle pulses.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bit_cnt    <= 4'd0;
            shift_q    <= 8'h00;
            parity_q   <= 1'b0;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall_q) begin
                if (bit_cnt == 4'd0) begin
                    // A high start bit is treated as line noise: stay put.
                    if (!data_s2) bit_cnt <= 4'd1;
                end else if (bit_cnt <= 4'd8) begin
                    shift_q <= {data_s2, shift_q[7:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end else if (bit_cnt == 4'd9) begin
                    parity_q <= data_s2;
                    bit_cnt  <= bit_cnt + 4'd1;
                end else begin
                    bit_cnt <= 4'd0;
                    if ((^shift_q ^ parity_q) && data_s2) begin
                        byte_valid <= 1'b1;
                        byte_data  <= shift_q;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
            end else if (timeout) begin
                bit_cnt   <= 4'd0;
                frame_err <= 1'b1;
            end
        end
    end

    // Idle-cycle counter measured from the most recent falling edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            to_cnt <= '0;
        end else if (fall_q || (bit_cnt == 4'd0) || timeout) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TW'(1);
        end
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// Decodes scan-code set 2 make/break sequences into level-held movement flags.
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic w_key,
    output logic a_key,
    output logic d_key,
    output logic up_key,
    output logic left_key,
    output logic right_key,
    output logic frame_err
);

    logic       byte_valid;
    logic [7:0] byte_data;

    dec_state_t state_q, state_d;
    key_flags_t flags_q, flags_d;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    // Decoder state and held flags.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    // Next-state and flag updates, advancing only on a received byte.
    always_comb begin
        // NOTE: hold-current defaults first, so every path assigns and no latch is inferred.
        state_d = state_q;
        flags_d = flags_q;
        if (frame_err) begin
            // A lost byte may have been a prefix; drop it, keep the flags.
            state_d = IDLE;
        end else if (byte_valid) begin
            case (state_q)
                IDLE: begin
                    if (byte_data == SC_E0)      state_d = EXT;
                    else if (byte_data == SC_F0) state_d = BRK;
                    else flags_d = apply_code(flags_q, 1'b0, byte_data, 1'b1);
                end
                EXT: begin
                    if (byte_data == SC_F0) begin
                        state_d = EXT_BRK;
                    end else begin
                        flags_d = apply_code(flags_q, 1'b1, byte_data, 1'b1);
                        state_d = IDLE;
                    end
                end
                BRK: begin
                    flags_d = apply_code(flags_q, 1'b0, byte_data, 1'b0);
                    state_d = IDLE;
                end
                EXT_BRK: begin
                    flags_d = apply_code(flags_q, 1'b1, byte_data, 1'b0);
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign w_key     = flags_q.w;
    assign a_key     = flags_q.a;
    assign d_key     = flags_q.d;
    assign up_key    = flags_q.up;
    assign left_key  = flags_q.left;
    assign right_key = flags_q.right;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker with a sequence-level key model.
module tb_ps2_key_tracker;

    logic Clk      = 1'b0;
    logic Reset_n  = 1'b0;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;
    logic w_key, a_key, d_key, up_key, left_key, right_key, frame_err;

    int n_tests = 0;
    int n_fail  = 0;
    int err_cnt = 0;

    // Reference model: six held flags, pending prefix bits, expected error count.
    bit m_flags[6];
    bit m_ext = 1'b0;
    bit m_brk = 1'b0;
    int m_err = 0;

    ps2_key_tracker #(.TIMEOUT_CYCLES(50000)) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .w_key    (w_key),
        .a_key    (a_key),
        .d_key    (d_key),
        .up_key   (up_key),
        .left_key (left_key),
        .right_key(right_key),
        .frame_err(frame_err)
    );

    always #10 Clk = ~Clk;

    // Every high cycle of frame_err counts; one-cycle pulses keep this equal to the pulse count.
    always @(negedge Clk) if (frame_err === 1'b1) err_cnt++;

    function automatic logic [5:0] dut_flags();
        return {right_key, left_key, up_key, d_key, a_key, w_key};
    endfunction

    function automatic logic [5:0] exp_flags();
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[i] = m_flags[i];
        return r;
    endfunction

    // Index order: 0 w, 1 a, 2 d, 3 up, 4 left, 5 right; -1 if not tracked.
    function automatic int code_index(input bit ext, input logic [7:0] code);
        if (!ext) begin
            if (code == 8'h1D) return 0;
            if (code == 8'h1C) return 1;
            if (code == 8'h23) return 2;
        end else begin
            if (code == 8'h75) return 3;
            if (code == 8'h6B) return 4;
            if (code == 8'h74) return 5;
        end
        return -1;
    endfunction

    task automatic model_byte(input logic [7:0] b);
        int idx;
        if (b == 8'hE0 && !m_ext && !m_brk) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0 && !m_brk) begin
            m_brk = 1'b1;
        end else begin
            idx = code_index(m_ext, b);
            if (idx >= 0) m_flags[idx] = !m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic model_error();
        m_ext = 1'b0;
        m_brk = 1'b0;
        m_err++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_flags[i] = 1'b0;
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic ps2_bit(input logic v);
        ps2_data = v;
        wait_clk(5);
        ps2_clk = 1'b0;
        wait_clk(10);
        ps2_clk = 1'b1;
        wait_clk(5);
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par);
        return {1'b1, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        logic [10:0] f;
        f = make_frame(b, bad_par);
        for (int i = 0; i < 11; i++) ps2_bit(f[i]);
        if (bad_par) model_error();
        else         model_byte(b);
    endtask

    task automatic test_reset();
        n_tests++;
        if (dut_flags() !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want %b", dut_flags(), 6'b0);
        end
        n_tests++;
        if (frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_frame_err: got %b want 0", frame_err);
        end
    endtask

    task automatic test_make_break();
        logic [10:0] f;
        f = make_frame(8'h1D, 1'b0);
        for (int i = 0; i < 10; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
        wait_clk(5);
        ps2_clk = 1'b0;
        wait_clk(4);
        n_tests++;
        if (w_key !== 1'b0) begin
            n_fail++;
            $display("FAIL w_latency_early: got %b want 0 at 4 cycles", w_key);
        end
        wait_clk(1);
        n_tests++;
        if (w_key !== 1'b1) begin
            n_fail++;
            $display("FAIL w_latency: got %b want 1 at 5 cycles", w_key);
        end
        wait_clk(5);
        ps2_clk = 1'b1;
        wait_clk(5);
        model_byte(8'h1D);
        n_tests++;
        if (dut_flags() !== 6'b000001) begin
            n_fail++;
            $display("FAIL w_make_only: got %b want %b", dut_flags(), 6'b000001);
        end
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1D, 1'b0);
        n_tests++;
        if (dut_flags() !== exp_flags()) begin
            n_fail++;
            $display("FAIL w_break: got %b want %b", dut_flags(), exp_flags());
        end
    endtask

    task automatic test_extended();
        send_frame(8'hE0, 1'b0);
        send_frame(8'h6B, 1'b0);
        n_tests++;
        if (left_key !== 1'b1 || a_key !== 1'b0 || dut_flags() !== exp_flags()) begin
            n_fail++;
            $display("FAIL ext_left_make: got %b want %b", dut_flags(), exp_flags());
        end
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h6B, 1'b0);
        n_tests++;
        if (left_key !== 1'b0 || dut_flags() !== exp_flags()) begin
            n_fail++;
            $display("FAIL ext_left_break: got %b want %b", dut_flags(), exp_flags());
        end
    endtask

    task automatic test_simultaneous();
        send_frame(8'h1C, 1'b0);
        send_frame(8'h23, 1'b0);
        n_tests++;
        if (a_key !== 1'b1 || d_key !== 1'b1 || dut_flags() !== exp_flags()) begin
            n_fail++;
            $display("FAIL simul_a_d: got %b want %b", dut_flags(), exp_flags());
        end
        for (int i = 0; i < 5; i++) begin
            send_frame(8'h1C, 1'b0);
            n_tests++;
            if (a_key !== 1'b1 || dut_flags() !== exp_flags()) begin
                n_fail++;
                $display("FAIL typematic_a[%0d]: got %b want %b", i, dut_flags(), exp_flags());
            end
        end
        // Release both so later scenarios start clean.
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h23, 1'b0);
    endtask

    task automatic test_parity_err();
        send_frame(8'h23, 1'b1);
        n_tests++;
        if (err_cnt !== m_err) begin
            n_fail++;
            $display("FAIL parity_err_pulse: got %0d err cycles want %0d", err_cnt, m_err);
        end
        n_tests++;
        if (d_key !== 1'b0 || dut_flags() !== exp_flags()) begin
            n_fail++;
            $display("FAIL parity_no_flag: got %b want %b", dut_flags(), exp_flags());
        end
        send_frame(8'h23, 1'b0);
        n_tests++;
        if (d_key !== 1'b1 || dut_flags() !== exp_flags()) begin
            n_fail++;
            $display("FAIL parity_recover: got %b want %b", dut_flags(), exp_flags());
        end
    endtask

    task automatic test_timeout();
        logic [10:0] f;
        int start_err;
        int waited;
        send_frame(8'hE0, 1'b0);
        f = make_frame(8'h75, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(f[i]);
        start_err = err_cnt;
        wait_clk(40000);
        n_tests++;
        if (err_cnt !== start_err) begin
            n_fail++;
            $display("FAIL timeout_early: got %0d err cycles want %0d", err_cnt, start_err);
        end
        waited = 0;
        while (err_cnt == start_err && waited < 11000) begin
            wait_clk(1);
            waited++;
        end
        wait_clk(2);
        model_error();
        n_tests++;
        if (err_cnt !== m_err) begin
            n_fail++;
            $display("FAIL timeout_pulse: got %0d err cycles want %0d", err_cnt, m_err);
        end
        send_frame(8'h75, 1'b0);
        n_tests++;
        if (up_key !== 1'b0 || dut_flags() !== exp_flags()) begin
            n_fail++;
            $display("FAIL timeout_prefix_cleared: got %b want %b", dut_flags(), exp_flags());
        end
    endtask

    task automatic test_reset_mid();
        send_frame(8'h1D, 1'b0);
        n_tests++;
        if (w_key !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_setup: got w=%b want 1", w_key);
        end
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_data = 1'b0;
        wait_clk(5);
        ps2_clk = 1'b0;
        #3;
        Reset_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (dut_flags() !== 6'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: got flags %b err %b want 000000 0", dut_flags(), frame_err);
        end
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_clk(5);
        Reset_n = 1'b1;
        wait_clk(5);
        send_frame(8'h1D, 1'b0);
        n_tests++;
        if (w_key !== 1'b1 || dut_flags() !== exp_flags()) begin
            n_fail++;
            $display("FAIL reset_recover: got %b want %b", dut_flags(), exp_flags());
        end
    endtask

    task automatic test_random();
        logic [7:0] codes [8];
        logic [7:0] b;
        bit         bad;
        codes[0] = 8'hE0; codes[1] = 8'hF0; codes[2] = 8'h1D; codes[3] = 8'h1C;
        codes[4] = 8'h23; codes[5] = 8'h75; codes[6] = 8'h6B; codes[7] = 8'h74;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) b = 8'($urandom);
            else                           b = codes[$urandom_range(0, 7)];
            bad = ($urandom_range(0, 9) == 0);
            send_frame(b, bad);
            n_tests++;
            if (dut_flags() !== exp_flags() || err_cnt !== m_err) begin
                n_fail++;
                $display("FAIL random[%0d] byte %h bad %0d: got %b err %0d want %b err %0d",
                         i, b, bad, dut_flags(), err_cnt, exp_flags(), m_err);
            end
        end
    endtask

    initial begin
        model_reset();
        wait_clk(3);
        test_reset();
        Reset_n = 1'b1;
        wait_clk(5);
        test_make_break();
        test_extended();
        test_simultaneous();
        test_parity_err();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
